// File: rtl/conv3x3_window_mac.sv
// 3x3 sliding-window convolution: three row taps -> 3x3 window -> 4-stage MAC pipeline
// with bias, arithmetic shift, ReLU and 8-bit saturation.
module conv3x3_window_mac #(
    parameter int P_COLS  = 150,
    parameter int P_ROWS  = 150,
    parameter int P_SHIFT = 7
) (
    input  logic        jct_i_clk,
    input  logic        jct_i_rst,
    input  logic [7:0]  jct_i_d_data0,
    input  logic [7:0]  jct_i_d_data1,
    input  logic [7:0]  jct_i_d_data2,
    input  logic        jct_i_c_valid,
    input  logic        jct_i_c_wload,
    input  logic [71:0] jct_i_d_weights,
    input  logic [15:0] jct_i_d_bias,
    output logic [7:0]  jct_o_d_pixel,
    output logic        jct_o_c_valid,
    output logic        jct_o_c_frame_done,
    output logic        jct_o_c_wload_err
);
    localparam int CW = $clog2(P_COLS + 1);
    localparam int RW = $clog2(P_ROWS + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(P_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(P_ROWS - 3);

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                idle, wload_ok;
    logic [7:0]          win_q [3][3];
    logic signed [7:0]   wgt_q [9];
    logic signed [15:0]  bias_q;
    logic                vld_p0_q, fd_p0_q;
    logic signed [16:0]  prod_p1_q [9];
    logic                vld_p1_q, fd_p1_q;
    logic signed [20:0]  sum_p2_q;
    logic                vld_p2_q, fd_p2_q;
    logic [7:0]          pix_p3_q;
    logic                vld_p3_q, fd_p3_q;
    logic                err_q;

    function automatic logic signed [16:0] mult(input logic [7:0] pix, input logic signed [7:0] w);
        logic signed [16:0] a;
        logic signed [16:0] b;
        a = {9'b0, pix};
        b = 17'(w);
        return a * b;
    endfunction

    function automatic logic [7:0] relu_sat(input logic signed [20:0] s);
        logic signed [20:0] v;
        v = s >>> P_SHIFT;
        if (v < 0)
            return 8'd0;
        else if (v > 21'sd255)
            return 8'hFF;
        return v[7:0];
    endfunction

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (jct_i_c_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A window already captured but not yet multiplied still needs the current kernel.
    assign idle     = (col_q == '0) && (row_q == '0) && !(vld_p0_q || vld_p1_q || vld_p2_q);
    assign wload_ok = jct_i_c_wload && idle;

    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            col_q  <= '0;
            row_q  <= '0;
            err_q  <= 1'b0;
            bias_q <= '0;
            for (int i = 0; i < 9; i++) wgt_q[i] <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            err_q <= jct_i_c_wload && !idle;
            if (wload_ok) begin
                bias_q <= $signed(jct_i_d_bias);
                for (int i = 0; i < 9; i++) wgt_q[i] <= $signed(jct_i_d_weights[i*8 +: 8]);
            end
        end
    end

    // Window capture (edge E)
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 3; j++) win_q[k][j] <= '0;
            vld_p0_q <= 1'b0;
            fd_p0_q  <= 1'b0;
        end else begin
            if (jct_i_c_valid) begin
                for (int k = 0; k < 3; k++) begin
                    win_q[k][0] <= win_q[k][1];
                    win_q[k][1] <= win_q[k][2];
                end
                win_q[0][2] <= jct_i_d_data1;
                win_q[1][2] <= jct_i_d_data2;
                win_q[2][2] <= jct_i_d_data0;
            end
            vld_p0_q <= jct_i_c_valid && (col_q >= CW'(2));
            fd_p0_q  <= jct_i_c_valid && (col_q == COL_LAST) && (row_q == ROW_LAST);
        end
    end

    // S1: products, S2: sum + bias, S3: shift / ReLU / saturate
    always_ff @(posedge jct_i_clk or posedge jct_i_rst) begin
        if (jct_i_rst) begin
            for (int i = 0; i < 9; i++) prod_p1_q[i] <= '0;
            sum_p2_q <= '0;
            pix_p3_q <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            fd_p1_q  <= 1'b0;
            fd_p2_q  <= 1'b0;
            fd_p3_q  <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 3; j++)
                    prod_p1_q[k*3+j] <= mult(win_q[k][j], wgt_q[k*3+j]);
            sum_p2_q <= 21'(bias_q) + 21'(prod_p1_q[0]) + 21'(prod_p1_q[1]) + 21'(prod_p1_q[2])
                      + 21'(prod_p1_q[3]) + 21'(prod_p1_q[4]) + 21'(prod_p1_q[5])
                      + 21'(prod_p1_q[6]) + 21'(prod_p1_q[7]) + 21'(prod_p1_q[8]);
            pix_p3_q <= relu_sat(sum_p2_q);
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            fd_p1_q  <= fd_p0_q;
            fd_p2_q  <= fd_p1_q;
            fd_p3_q  <= fd_p2_q;
        end
    end

    assign jct_o_d_pixel      = pix_p3_q;
    assign jct_o_c_valid      = vld_p3_q;
    assign jct_o_c_frame_done = fd_p3_q;
    assign jct_o_c_wload_err  = err_q;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Randomized bench for conv3x3_window_mac against a frame-level convolution model.
module tb_conv3x3_window_mac;
    localparam int COLS  = 150;
    localparam int ROWS  = 150;
    localparam int SHIFT = 2;
    localparam int NOUT  = COLS - 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d0 = '0, d1 = '0, d2 = '0;
    logic        vld = 1'b0, wl = 1'b0;
    logic [71:0] wbus = '0;
    logic [15:0] bbus = '0;
    logic [7:0]  o_px;
    logic        o_valid, o_fd, o_err;

    typedef struct { int px; int fd; int cyc; } exp_t;
    exp_t q[$];
    int   fd_snap[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_out = 0, fd_cnt = 0, err_cnt = 0;
    int m_col = 0, m_row = 0, bias_m = 0;
    int kern_m [9];
    int top_m [COLS], mid_m [COLS], bot_m [COLS];
    int e0, base;

    conv3x3_window_mac #(.P_COLS(COLS), .P_ROWS(ROWS), .P_SHIFT(SHIFT)) dut (
        .jct_i_clk(clk), .jct_i_rst(rst),
        .jct_i_d_data0(d0), .jct_i_d_data1(d1), .jct_i_d_data2(d2),
        .jct_i_c_valid(vld), .jct_i_c_wload(wl),
        .jct_i_d_weights(wbus), .jct_i_d_bias(bbus),
        .jct_o_d_pixel(o_px), .jct_o_c_valid(o_valid),
        .jct_o_c_frame_done(o_fd), .jct_o_c_wload_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_px(input int s);
        int v;
        v = s >>> SHIFT;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [71:0] kern_fill(input int v);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [71:0] kern_rand();
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'($urandom_range(255, 0));
        return r;
    endfunction

    task automatic load_model();
        for (int i = 0; i < 9; i++) kern_m[i] = int'($signed(wbus[i*8 +: 8]));
        bias_m = int'($signed(bbus));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_err) err_cnt++;
            if (o_fd) begin
                fd_cnt++;
                fd_snap.push_back(n_out + 1);
                if (!o_valid) chk("frame_done_without_valid", 1, 0);
            end
            if (o_valid) begin
                exp_t e;
                n_out++;
                if (q.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("pixel", int'(o_px), e.px);
                    chk("frame_done", int'(o_fd), e.fd);
                    chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld = 1'b0;
            wl  = 1'b0;
        end
    endtask

    task automatic beat(input int a0, input int a1, input int a2, input bit do_wl, input bit wl_acc);
        exp_t e;
        int   s;
        @(negedge clk);
        vld = 1'b1;
        d0 = 8'(a0); d1 = 8'(a1); d2 = 8'(a2);
        wl = do_wl;
        if (do_wl && wl_acc) load_model();
        bot_m[m_col] = a0; top_m[m_col] = a1; mid_m[m_col] = a2;
        if (m_col >= 2) begin
            s = bias_m;
            for (int j = 0; j < 3; j++)
                s += kern_m[j] * top_m[m_col-2+j] + kern_m[3+j] * mid_m[m_col-2+j]
                   + kern_m[6+j] * bot_m[m_col-2+j];
            e.px  = ref_px(s);
            e.fd  = (m_row == ROWS - 3 && m_col == COLS - 1) ? 1 : 0;
            e.cyc = cyc + 4;
            q.push_back(e);
        end
        if (m_col == COLS - 1) begin
            m_col = 0;
            m_row = (m_row == ROWS - 3) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // mode: 0 = data2 carries the column index, 1 = all 255, 2 = all 0, 3 = random
    task automatic run_row(input int mode, input int gap, input int wl_col, input bit wl_acc);
        int a0, a1, a2;
        for (int c = 0; c < COLS; c++) begin
            a0 = $urandom_range(255, 0); a1 = $urandom_range(255, 0); a2 = $urandom_range(255, 0);
            if (mode == 0) a2 = m_col;
            if (mode == 1) begin a0 = 255; a1 = 255; a2 = 255; end
            if (mode == 2) begin a0 = 0; a1 = 0; a2 = 0; end
            beat(a0, a1, a2, c == wl_col, wl_acc);
            idle($urandom_range(gap, 0));
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            idle(1);
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic set_kernel(input logic [71:0] w, input logic [15:0] b, input bit acc);
        int e;
        e = err_cnt;
        @(negedge clk);
        wbus = w; bbus = b; wl = 1'b1; vld = 1'b0;
        if (acc) load_model();
        @(negedge clk);
        wl = 1'b0;
        @(negedge clk);
        #1;
        chk("wload_err_count", err_cnt - e, acc ? 0 : 1);
    endtask

    task automatic do_reset(input bit expect_busy);
        @(negedge clk);
        if (expect_busy) chk("busy_before_reset", int'(o_valid), 1);
        rst = 1'b1; vld = 1'b0; wl = 1'b0;
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_pixel", int'(o_px), 0);
        chk("rst_frame_done", int'(o_fd), 0);
        chk("rst_wload_err", int'(o_err), 0);
        q.delete();
        m_col = 0; m_row = 0; bias_m = 0;
        for (int i = 0; i < 9; i++) kern_m[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 9; i++) kern_m[i] = 0;
        #1;
        chk("init_valid", int'(o_valid), 0);
        chk("init_pixel", int'(o_px), 0);
        do_reset(1'b0);

        // mid-stream reset, then a row with the cleared (zero) kernel
        set_kernel(kern_rand(), 16'(200), 1'b1);
        for (int c = 0; c < 20; c++) beat(255, 255, 255, 1'b0, 1'b0);
        do_reset(1'b1);
        idle(10);
        run_row(3, 0, -1, 1'b0);
        drain();

        // identity kernel, column ramp, then the same with random gaps
        do_reset(1'b0);
        wbus = '0; wbus[4*8 +: 8] = 8'(1 << SHIFT);
        set_kernel(wbus, 16'd0, 1'b1);
        e0 = n_out;
        run_row(0, 0, -1, 1'b0);
        drain();
        chk("identity_count", n_out - e0, NOUT);
        do_reset(1'b0);
        set_kernel(wbus, 16'd0, 1'b1);
        e0 = n_out;
        run_row(0, 3, -1, 1'b0);
        drain();
        chk("gapped_count", n_out - e0, NOUT);

        // saturation, ReLU, minimum bias
        do_reset(1'b0);
        set_kernel(kern_fill(127), 16'd0, 1'b1);
        run_row(1, 0, -1, 1'b0);
        drain();
        do_reset(1'b0);
        set_kernel(kern_fill(-1), 16'd0, 1'b1);
        run_row(1, 1, -1, 1'b0);
        drain();
        do_reset(1'b0);
        set_kernel('0, 16'h8000, 1'b1);
        run_row(2, 0, -1, 1'b0);
        drain();

        // rejected load while busy, accepted load together with the first beat
        do_reset(1'b0);
        set_kernel(kern_rand(), 16'($urandom_range(2000, 0)), 1'b1);
        e0 = err_cnt;
        wbus = kern_rand();
        run_row(3, 0, 10, 1'b0);
        drain();
        chk("busy_wload_err", err_cnt - e0, 1);
        set_kernel(kern_rand(), 16'd0, 1'b0);
        do_reset(1'b0);
        set_kernel(kern_rand(), 16'd0, 1'b1);
        e0 = err_cnt;
        wbus = kern_rand(); bbus = 16'($urandom_range(65535, 0));
        run_row(3, 0, 0, 1'b1);
        drain();
        chk("idle_wload_err", err_cnt - e0, 0);

        // two full frames back to back, then an idle reload
        do_reset(1'b0);
        set_kernel(kern_rand(), 16'($urandom_range(4000, 0)), 1'b1);
        fd_snap.delete();
        base = n_out;
        e0 = fd_cnt;
        for (int r = 0; r < 2 * (ROWS - 2); r++) run_row(3, 0, -1, 1'b0);
        drain();
        chk("two_frame_count", n_out - base, 2 * NOUT * (ROWS - 2));
        chk("frame_done_pulses", fd_cnt - e0, 2);
        chk("frame_done_snaps", fd_snap.size(), 2);
        if (fd_snap.size() >= 2) begin
            chk("frame1_done_pos", fd_snap[0] - base, NOUT * (ROWS - 2));
            chk("frame2_done_pos", fd_snap[1] - base, 2 * NOUT * (ROWS - 2));
        end
        set_kernel(kern_rand(), 16'($urandom_range(65535, 0)), 1'b1);
        run_row(3, 2, -1, 1'b0);
        drain();

        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
